// File: rtl/intr_sample_collector.sv
// Interrupt service FSM feeding a small FIFO that a host drains.
// Optional running min/max of accepted words: INTR_SAMPLE_COLLECTOR_MINMAX_EN.
module intr_sample_collector #(
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     intr,
  input  logic [7:0]               din,
  output logic                     intr_ack,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt,
`ifdef INTR_SAMPLE_COLLECTOR_MINMAX_EN
  output logic [7:0]               min_val,
  output logic [7:0]               max_val,
`endif
  output logic                     ack_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT_CLR
  } state_t;

  state_t state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic retry_q, retry_d;
  logic [7:0] cap_q;
  logic cap_ld, err_set;

  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic service, push, pop, drop;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    cap_ld  = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (intr) begin
          cap_ld  = 1'b1;
          retry_d = 1'b0;
          state_d = ACK;
        end
      end
      ACK: begin
        timer_d = 8'd0;
        state_d = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!intr) begin
          state_d = IDLE;
        end else if (timer_q == TO_LAST) begin
          // upstream missed the ack; pulse again but never re-push
          state_d = ACK;
          retry_d = 1'b1;
          err_set = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_C);
  assign count   = count_q;
  assign service = (state_q == ACK) && !retry_q;
  assign pop     = rd_en && !empty;
  assign push    = service && (!full || pop);
  assign drop    = service && !push;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= 8'd0;
      retry_q  <= 1'b0;
      cap_q    <= 8'd0;
      intr_ack <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      intr_ack <= (state_d == ACK);
      if (cap_ld) cap_q <= din;
      if (err_set) ack_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cap_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      rd_data  <= 8'd0;
      rd_valid <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      rd_valid <= pop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      if (push && !pop) count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef INTR_SAMPLE_COLLECTOR_MINMAX_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      min_val <= 8'hFF;
      max_val <= 8'h00;
    end else if (push) begin
      if (cap_q < min_val) min_val <= cap_q;
      if (cap_q > max_val) max_val <= cap_q;
    end
  end
`endif

endmodule

// File: tb/tb_intr_sample_collector.sv
// Bench for intr_sample_collector: table vectors, corner sequences, random run.
module tb_intr_sample_collector;

  localparam int DEPTH = 8;
  localparam int TO    = 15;

  logic clk = 1'b0;
  logic reset, intr, rd_en;
  logic [7:0] din;
  logic intr_ack, rd_valid, empty, full, ack_err;
  logic [7:0] rd_data, drop_cnt;
  logic [3:0] count;
`ifdef INTR_SAMPLE_COLLECTOR_MINMAX_EN
  logic [7:0] min_val, max_val;
`endif

  intr_sample_collector #(.DEPTH(DEPTH), .ACK_TIMEOUT(TO)) dut (
    .clk(clk),
    .reset(reset),
    .intr(intr),
    .din(din),
    .intr_ack(intr_ack),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .empty(empty),
    .full(full),
    .count(count),
    .drop_cnt(drop_cnt),
`ifdef INTR_SAMPLE_COLLECTOR_MINMAX_EN
    .min_val(min_val),
    .max_val(max_val),
`endif
    .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference: queue of accepted words plus counters
  logic [7:0] q[$];
  int m_drop;
  int m_min, m_max;
  logic [7:0] last_rd;

  typedef struct {
    int         op;
    logic [7:0] d;
    int         exp_cnt;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t tbl[22];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic m_clear();
    q.delete();
    m_drop = 0;
    m_min = 255;
    m_max = 0;
    last_rd = 8'd0;
  endtask

  task automatic m_accept(input logic [7:0] d);
    if (q.size() < DEPTH) begin
      q.push_back(d);
      if (int'(d) < m_min) m_min = int'(d);
      if (int'(d) > m_max) m_max = int'(d);
    end else if (m_drop < 255) begin
      m_drop++;
    end
  endtask

  task automatic check_state();
    chk("count", 32'(count), 32'(q.size()));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
`ifdef INTR_SAMPLE_COLLECTOR_MINMAX_EN
    chk("min_val", 32'(min_val), 32'(m_min));
    chk("max_val", 32'(max_val), 32'(m_max));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    intr = 1'b0;
    rd_en = 1'b0;
    din = 8'd0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(intr_ack), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_ack_err", 32'(ack_err), 0);
    m_clear();
    check_state();
    reset = 1'b0;
  endtask

  task automatic do_event(input logic [7:0] d, input bit pop_at_exit);
    bit got, exp_v;
    logic [7:0] exp_rd;
    got = 1'b0;
    exp_rd = 8'd0;
    din = d;
    intr = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (intr_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("ack_seen", 32'(got), 1);
    intr = 1'b0;
    rd_en = pop_at_exit;
    exp_v = pop_at_exit && (q.size() > 0);
    if (exp_v) exp_rd = q.pop_front();
    m_accept(d);
    @(posedge clk);
    @(negedge clk);
    rd_en = 1'b0;
    chk("ack_pulse", 32'(intr_ack), 0);
    chk("cnt_at_exit", 32'(count), 32'(q.size()));
    if (pop_at_exit) begin
      chk("ev_rd_valid", 32'(rd_valid), 32'(exp_v));
      if (exp_v) begin
        chk("ev_rd_data", 32'(rd_data), 32'(exp_rd));
        last_rd = exp_rd;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  task automatic do_pop(output logic [7:0] v);
    logic [7:0] e;
    rd_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd_en = 1'b0;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pop_valid", 32'(rd_valid), 1);
      chk("pop_data", 32'(rd_data), 32'(e));
      last_rd = e;
    end else begin
      chk("pop_empty_valid", 32'(rd_valid), 0);
      chk("pop_empty_hold", 32'(rd_data), 32'(last_rd));
    end
    v = rd_data;
    check_state();
  endtask

  task automatic stuck_run(input string tag);
    int acks[$];
    int err_mid;
    err_mid = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (intr_ack) acks.push_back(i);
      if (i == 10) err_mid = int'(ack_err);
    end
    chk({tag, "_acks"}, 32'(acks.size()), 4);
    for (int k = 0; k < acks.size(); k++)
      chk({tag, "_ack_pos"}, 32'(acks[k]), 32'(k * (TO + 1)));
    chk({tag, "_err_early"}, 32'(err_mid), 0);
    chk({tag, "_ack_err"}, 32'(ack_err), 1);
    chk({tag, "_one_push"}, 32'(count), 1);
  endtask

  initial begin
    logic [7:0] v;
    m_clear();
    reset = 1'b1;
    intr = 1'b0;
    rd_en = 1'b0;
    din = 8'd0;
    for (int i = 0; i < 8; i++)
      tbl[i] = '{0, 8'((i + 1) * 10), i + 1, 8'd0};
    tbl[8]  = '{1, 8'd0, 7, 8'd10};
    tbl[9]  = '{1, 8'd0, 6, 8'd20};
    tbl[10] = '{1, 8'd0, 5, 8'd30};
    tbl[11] = '{0, 8'd90, 6, 8'd0};
    tbl[12] = '{0, 8'd100, 7, 8'd0};
    tbl[13] = '{0, 8'd110, 8, 8'd0};
    for (int i = 0; i < 8; i++)
      tbl[14 + i] = '{1, 8'd0, 7 - i, 8'(40 + i * 10)};

    @(negedge clk);
    do_reset();

    // single event then pop
    do_event(8'd100, 1'b0);
    chk("single_cnt", 32'(count), 1);
    do_pop(v);
    chk("single_data", 32'(v), 100);
    chk("single_empty", 32'(empty), 1);
    do_pop(v);

    // ordering and wrap
    do_reset();
    foreach (tbl[i]) begin
      if (tbl[i].op == 0) begin
        do_event(tbl[i].d, 1'b0);
      end else begin
        do_pop(v);
        chk("tbl_rd", 32'(v), 32'(tbl[i].exp_rd));
      end
      chk("tbl_cnt", 32'(count), 32'(tbl[i].exp_cnt));
      if (i == 7) chk("tbl_full", 32'(full), 1);
    end

    // overflow and saturation
    do_reset();
    for (int i = 0; i < 8; i++) do_event(8'(i * 3 + 1), 1'b0);
    for (int i = 0; i < 3; i++) do_event(8'(240 + i), 1'b0);
    chk("ovf_drop3", 32'(drop_cnt), 3);
    for (int i = 0; i < 260; i++) do_event(8'(i), 1'b0);
    chk("ovf_sat", 32'(drop_cnt), 255);
    for (int i = 0; i < 8; i++) begin
      do_pop(v);
      chk("ovf_data", 32'(v), 32'(i * 3 + 1));
    end

    // full with pop on the ack-exit edge
    do_reset();
    for (int i = 0; i < 8; i++) do_event(8'(i + 1), 1'b0);
    do_event(8'd200, 1'b1);
    chk("fullpop_cnt", 32'(count), 8);
    chk("fullpop_drop", 32'(drop_cnt), 0);
    for (int i = 0; i < 8; i++) do_pop(v);
    chk("fullpop_last", 32'(v), 200);

`ifdef INTR_SAMPLE_COLLECTOR_MINMAX_EN
    do_reset();
    do_event(8'd50, 1'b0);
    do_event(8'd220, 1'b0);
    do_event(8'd35, 1'b0);
    chk("mm_min", 32'(min_val), 35);
    chk("mm_max", 32'(max_val), 220);
    for (int i = 0; i < 5; i++) do_event(8'd100, 1'b0);
    do_event(8'd5, 1'b0);
    chk("mm_drop_min", 32'(min_val), 35);
`endif

    // stuck intr, then reset while held
    do_reset();
    din = 8'd7;
    intr = 1'b1;
    stuck_run("stuck");
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stuck_rst_err", 32'(ack_err), 0);
    chk("stuck_rst_cnt", 32'(count), 0);
    chk("stuck_rst_ack", 32'(intr_ack), 0);
    reset = 1'b0;
    stuck_run("stuck2");
    intr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // randomized run against the queue model
    do_reset();
    for (int it = 0; it < 400; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        do_event(8'($urandom), $urandom_range(0, 3) == 0);
      end else if (r < 8) begin
        do_pop(v);
      end else begin
        @(posedge clk);
        @(negedge clk);
        check_state();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
